// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply and an
// optional restoring divider, ARM-style NZCV flags, valid/ready on both sides.
// Build option: define ALU_SEQ_DIV_EN to compile in the UDIV/UREM divider.
module alu_seq #(
  parameter int unsigned N      = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   nzcv
);

  localparam int unsigned SW    = $clog2(N);
  localparam int unsigned CW    = $clog2(N);
  localparam int unsigned STEPS = N / UNROLL;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpMul  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b1000;
  localparam logic [3:0] OpOrr  = 4'b1001;
  localparam logic [3:0] OpEor  = 4'b1010;
  localparam logic [3:0] OpLsl  = 4'b1011;
  localparam logic [3:0] OpLsr  = 4'b1100;
  localparam logic [3:0] OpAsr  = 4'b1101;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OpUdiv = 4'b0110;
  localparam logic [3:0] OpUrem = 4'b0111;

  typedef enum logic [1:0] {StIdle, StMul, StDone, StDiv} state_t;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_t;
`endif

  state_t         state_q, state_d;
  // ma: multiplicand / divisor, mb: multiplier / dividend-quotient, acc: product / remainder
  logic [N-1:0]   ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [N-1:0]   result_q, result_d;
  logic [3:0]     nzcv_q, nzcv_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   sc_res;
  logic           sc_c, sc_v;
  logic [N:0]     sc_wide;
  logic [SW-1:0]  amt;
  logic [N-1:0]   mul_acc_nxt;

`ifdef ALU_SEQ_DIV_EN
  logic           sel_rem_q, sel_rem_d, dz_q, dz_d;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_sub, div_rem_nxt, div_quo_nxt, div_res;
`endif

  assign amt       = b[SW-1:0];
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign nzcv      = nzcv_q;

  // Single-cycle datapath: result plus C/V for the op on the live inputs
  always_comb begin
    sc_res  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    sc_wide = '0;
    case (op)
      OpAdd: begin
        sc_wide = {1'b0, a} + {1'b0, b};
        sc_res  = sc_wide[N-1:0];
        sc_c    = sc_wide[N];
        sc_v    = (a[N-1] == b[N-1]) && (sc_res[N-1] != a[N-1]);
      end
      OpSub: begin
        sc_wide = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
        sc_res  = sc_wide[N-1:0];
        sc_c    = sc_wide[N];
        sc_v    = (a[N-1] != b[N-1]) && (sc_res[N-1] != a[N-1]);
      end
      OpAnd: sc_res = a & b;
      OpOrr: sc_res = a | b;
      OpEor: sc_res = a ^ b;
      // Shifts carry an extra guard bit so the last bit shifted out lands there (0 for amt 0)
      OpLsl: begin
        sc_wide = {1'b0, a} << amt;
        sc_res  = sc_wide[N-1:0];
        sc_c    = sc_wide[N];
      end
      OpLsr: begin
        sc_wide = {a, 1'b0} >> amt;
        sc_res  = sc_wide[N:1];
        sc_c    = sc_wide[0];
      end
      OpAsr: begin
        sc_wide = $signed({a, 1'b0}) >>> amt;
        sc_res  = sc_wide[N:1];
        sc_c    = sc_wide[0];
      end
      default: ;
    endcase
  end

  // One multiply step: add shifted multiplicand for each of the UNROLL low multiplier bits
  always_comb begin
    mul_acc_nxt = acc_q;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (mb_q[i]) mul_acc_nxt = mul_acc_nxt + (ma_q << i);
    end
  end

`ifdef ALU_SEQ_DIV_EN
  // One restoring-division step; b==0 naturally yields all-ones quotient and remainder a
  always_comb begin
    div_shift   = {acc_q, mb_q[N-1]};
    div_ge      = (div_shift >= {1'b0, ma_q});
    div_sub     = div_shift[N-1:0] - ma_q;
    div_rem_nxt = div_ge ? div_sub : div_shift[N-1:0];
    div_quo_nxt = {mb_q[N-2:0], div_ge};
    div_res     = sel_rem_q ? div_rem_nxt : div_quo_nxt;
  end
`endif

  // Next-state, iteration and result/flag capture
  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    nzcv_d    = nzcv_q;
`ifdef ALU_SEQ_DIV_EN
    sel_rem_d = sel_rem_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (op == OpMul) begin
            ma_d    = a;
            mb_d    = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StMul;
`ifdef ALU_SEQ_DIV_EN
          end else if (op == OpUdiv || op == OpUrem) begin
            ma_d      = b;
            mb_d      = a;
            acc_d     = '0;
            cnt_d     = '0;
            sel_rem_d = (op == OpUrem);
            dz_d      = (b == '0);
            state_d   = StDiv;
`endif
          end else begin
            result_d = sc_res;
            nzcv_d   = {sc_res[N-1], (sc_res == '0), sc_c, sc_v};
            state_d  = StDone;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc_nxt;
        ma_d  = ma_q << UNROLL;
        mb_d  = mb_q >> UNROLL;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          result_d = mul_acc_nxt;
          nzcv_d   = {mul_acc_nxt[N-1], (mul_acc_nxt == '0), 2'b00};
          state_d  = StDone;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      StDiv: begin
        acc_d = div_rem_nxt;
        mb_d  = div_quo_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          result_d = div_res;
          nzcv_d   = {div_res[N-1], (div_res == '0), 1'b0, dz_q};
          state_d  = StDone;
        end
      end
`endif
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      nzcv_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
      sel_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      nzcv_q    <= nzcv_d;
`ifdef ALU_SEQ_DIV_EN
      sel_rem_q <= sel_rem_d;
      dz_q      <= dz_d;
`endif
    end
  end

endmodule
